// File: rtl/rf_pkg.sv
// Register-file constants shared by the register file and the writeback arbiter.
package rf_pkg;

  localparam int RF_AW   = 5;
  localparam int RF_DW   = 32;
  localparam int RF_NREG = 32;

  localparam logic [RF_AW-1:0] ZERO_REG = 5'd0;

  // Width of an index into n entries, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_chk.sv
// Runtime checks for the writeback arbiter: pointer range and grant exclusivity.
module rf_wb_arbiter_chk #(
  parameter int N_REQ = 3,
  parameter int PW    = 2
) (
  input logic             clk,
  input logic             rst,
  input logic [PW-1:0]    rr_ptr,
  input logic [N_REQ-1:0] req_ready
);

  ptr_in_range: assert property (@(posedge clk) disable iff (rst) 32'(rr_ptr) < N_REQ);

  grant_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: purely combinational rotate / priority-encode / unrotate.
// The request vector is rotated so that bit i_ptr sits at position 0.
// The lowest set bit is then picked, and the position is mapped back to a requester index.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_gnt_idx,
  output logic          o_gnt_any
);

  localparam int PW1 = PW + 1;

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW-1:0]  w_pos;
  logic           w_found;
  logic [PW1-1:0] w_sum;

  // Rotate, priority-encode from position 0, then translate back to an absolute index.
  always_comb begin
    w_dbl   = {i_req, i_req} >> i_ptr;
    w_rot   = w_dbl[N-1:0];
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_pos   = PW'(i);
      end else begin
        w_found = w_found;
      end
    end
    w_sum = PW1'(i_ptr) + PW1'(w_pos);
    if (w_sum >= PW1'(N)) begin
      w_sum = w_sum - PW1'(N);
    end else begin
      w_sum = w_sum;
    end
    o_gnt_idx = w_sum[PW-1:0];
    o_gnt_any = w_found;
    if (w_found) begin
      o_gnt = {{(N-1){1'b0}}, 1'b1} << w_sum[PW-1:0];
    end else begin
      o_gnt = '0;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file write port among N_REQ writeback requesters.
// A round-robin grant selects one requester, and a single registered stage drives RFWr/A3/WD.
// Writes to r0 complete the handshake but never assert RFWr.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int  N_REQ = 3,
  parameter int  AW    = RF_AW,
  parameter int  DW    = RF_DW,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_stall,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               RFWr,
  output logic [AW-1:0]      A3,
  output logic [DW-1:0]      WD,
  output logic [PW-1:0]      rr_ptr
);

  logic [N_REQ-1:0] w_req_m;
  logic [N_REQ-1:0] w_gnt;
  logic [PW-1:0]    w_gnt_idx;
  logic             w_gnt_any;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [PW-1:0]    w_ptr_nxt;

  logic             r_wr;
  logic [AW-1:0]    r_a3;
  logic [DW-1:0]    r_wd;
  logic [PW-1:0]    r_ptr;

  // Stall or reset hides every request from the arbiter, so no grant can escape.
  always_comb begin
    if (wb_stall || rst) begin
      w_req_m = '0;
    end else begin
      w_req_m = req_valid;
    end
  end

  rr_arbiter #(
    .N  (N_REQ),
    .PW (PW)
  ) u_arb (
    .i_req     (w_req_m),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_gnt_any (w_gnt_any)
  );

  assign req_ready = w_gnt;

  // Select the winner's address and data, and compute the pointer that follows the winner.
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_addr = (w_gnt_idx == PW'(i)) ? req_addr[i*AW +: AW] : w_addr;
      w_data = (w_gnt_idx == PW'(i)) ? req_data[i*DW +: DW] : w_data;
    end
    if (w_gnt_idx == PW'(N_REQ - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gnt_idx + PW'(1'b1);
    end
  end

  // Write stage: capture the granted write; without a grant, only the enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= 1'b0;
      r_a3  <= '0;
      r_wd  <= '0;
      r_ptr <= '0;
    end else if (w_gnt_any) begin
      r_wr  <= (w_addr != AW'(ZERO_REG));
      r_a3  <= w_addr;
      r_wd  <= w_data;
      r_ptr <= w_ptr_nxt;
    end else begin
      r_wr  <= 1'b0;
      r_a3  <= r_a3;
      r_wd  <= r_wd;
      r_ptr <= r_ptr;
    end
  end

  assign RFWr   = r_wr;
  assign A3     = r_a3;
  assign WD     = r_wd;
  assign rr_ptr = r_ptr;

  rf_wb_arbiter_chk #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_chk (
    .clk       (clk),
    .rst       (rst),
    .rr_ptr    (r_ptr),
    .req_ready (w_gnt)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter.
// It runs directed scenarios and then randomized traffic.
// Expected values come from a behavioural model: a round-robin scan over an integer
// pointer, a one-entry write stage, and an array register file.
module tb_rf_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wb_stall;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            RFWr;
  logic [AW-1:0]   A3;
  logic [DW-1:0]   WD;
  logic [PW-1:0]   rr_ptr;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_stall  (wb_stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .RFWr      (RFWr),
    .A3        (A3),
    .WD        (WD),
    .rr_ptr    (rr_ptr)
  );

  always #5 clk = ~clk;

  // Register file driven by the DUT's write port.
  logic [DW-1:0] tb_rf [32] = '{default: '0};
  always @(posedge clk) if (RFWr) tb_rf[A3] <= WD;

  // Reference model state
  int            m_ptr;
  logic          m_wr;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_rf [32];
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  int            last_g;
  logic [N-1:0]  obs_rdy;
  int            waitc [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_wr  = 1'b0;
    m_a3  = '0;
    m_wd  = '0;
  endtask

  // One clock cycle: check the combinational grant, then the registered stage after the edge.
  task automatic cyc();
    drive();
    #1;
    last_g = -1;
    if (!rst && !wb_stall) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (last_g < 0 && req_valid[idx]) last_g = idx;
      end
    end
    obs_rdy = req_ready;
    chk("ready", obs_rdy, (last_g >= 0) ? (64'd1 << last_g) : 64'd0);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_wr) m_rf[m_a3] = m_wd;
      if (last_g >= 0) begin
        m_a3  = a[last_g];
        m_wd  = d[last_g];
        m_wr  = (a[last_g] != 0);
        m_ptr = (last_g + 1) % N;
      end else begin
        m_wr = 1'b0;
      end
    end
    #1;
    chk("RFWr", RFWr, m_wr);
    chk("A3", A3, m_a3);
    chk("WD", WD, m_wd);
    chk("rr_ptr", rr_ptr, m_ptr);
    chk("r0_zero", tb_rf[0], 64'd0);
    chk("rf_entry", tb_rf[m_a3], m_rf[m_a3]);
  endtask

  task automatic chk_rf();
    for (int r = 0; r < 32; r++) chk("rf_all", tb_rf[r], m_rf[r]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int r = 0; r < 32; r++) m_rf[r] = '0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    model_reset();

    // 1. Reset held with every requester valid
    rst = 1'b1; wb_stall = 1'b0; req_valid = '1;
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = 32'hA000_0001; d[1] = 32'hA000_0002; d[2] = 32'hA000_0003;
    drive();
    #1;
    chk("rst_ready", req_ready, 64'd0);
    chk("rst_RFWr", RFWr, 64'd0);
    chk("rst_A3", A3, 64'd0);
    chk("rst_WD", WD, 64'd0);
    chk("rst_ptr", rr_ptr, 64'd0);
    cyc(); cyc();
    rst = 1'b0;

    // 3. All valid and held: grants rotate 0,1,2,0,1,2
    for (int s = 0; s < 6; s++) begin
      cyc();
      chk("rot_grant", obs_rdy, 64'd1 << (s % 3));
      chk("rot_wr", RFWr, 64'd1);
      chk("rot_ptr", rr_ptr, (s + 1) % 3);
    end
    req_valid = '0;
    cyc();
    chk_rf();

    // 2. Single write from requester 1
    req_valid = 3'b010; a[1] = 5'd5; d[1] = 32'h1234_5678;
    cyc();
    req_valid = '0;
    chk("t2_ready", obs_rdy, 64'h2);
    chk("t2_wr", RFWr, 64'd1);
    chk("t2_a3", A3, 64'd5);
    chk("t2_wd", WD, 64'h1234_5678);
    cyc();
    chk("t2_rf5", tb_rf[5], 64'h1234_5678);

    // 4. Write to r0 is accepted and dropped
    req_valid = 3'b100; a[2] = 5'd0; d[2] = 32'hFFFF_FFFF;
    cyc();
    req_valid = '0;
    chk("t4_ready", obs_rdy, 64'h4);
    chk("t4_wr", RFWr, 64'd0);
    chk("t4_ptr", rr_ptr, 64'd0);
    cyc();
    chk("t4_r0", tb_rf[0], 64'd0);

    // 5. Stall blocks grants; releasing it grants in the same cycle
    req_valid = 3'b001; a[0] = 5'd7; d[0] = 32'hCAFE_0007; wb_stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      cyc();
      chk("t5_ready", obs_rdy, 64'd0);
      chk("t5_wr", RFWr, 64'd0);
    end
    wb_stall = 1'b0;
    cyc();
    req_valid = '0;
    chk("t5_grant", obs_rdy, 64'h1);
    chk("t5_wr_on", RFWr, 64'd1);
    chk("t5_a3", A3, 64'd7);
    cyc();
    chk("t5_rf7", tb_rf[7], 64'hCAFE_0007);

    // 6. Async reset while the stage holds a write
    req_valid = 3'b001; a[0] = 5'd9; d[0] = 32'hDEAD_0009;
    cyc();
    req_valid = '0;
    chk("t6_pre", RFWr, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_wr", RFWr, 64'd0);
    chk("t6_async_a3", A3, 64'd0);
    chk("t6_async_wd", WD, 64'd0);
    chk("t6_async_ptr", rr_ptr, 64'd0);
    model_reset();
    req_valid = 3'b010; a[1] = 5'd11; d[1] = 32'hBEEF_0011;
    cyc();
    chk("t6_rst_ready", obs_rdy, 64'd0);
    rst = 1'b0;
    cyc();
    req_valid = '0;
    chk("t6_grant", obs_rdy, 64'h2);
    cyc();
    chk("t6_dropped", tb_rf[9], 64'd0);
    chk("t6_r11", tb_rf[11], 64'hBEEF_0011);
    chk_rf();

    // Randomized traffic honouring the requester contract
    for (int c = 0; c < 400; c++) begin
      wb_stall = (($urandom % 5) == 0);
      cyc();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (obs_rdy[i]) begin
            chk("no_starve", (waitc[i] <= N - 1), 64'd1);
            waitc[i] = 0;
          end else if (!wb_stall) begin
            waitc[i]++;
          end
        end
        if (!req_valid[i] || obs_rdy[i]) begin
          req_valid[i] = (($urandom % 3) != 0);
          a[i] = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom % 32);
          d[i] = $urandom;
          waitc[i] = 0;
        end
      end
    end
    wb_stall = 1'b0;
    req_valid = '0;
    cyc();
    cyc();
    chk_rf();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
